psum_tile_sender: RTL and testbench
===================================

# psum_tile_sender

Accumulates signed per-row product vectors from the systolic array across K passes into a 16-row × 16-lane × 24-bit tile buffer. When the tile is complete, it streams the tile to the post-processing unit as a valid pulse followed by 16 consecutive rows. It then holds until the post-processing unit signals completion. The block sits between the array output and the post-processing unit's partial-sum input and acts as that interface's transmitter.

## Interface
- LANES, 16, lanes per row; fixed at 16 for the post-processing unit
- ROWS, 16, rows per tile; must equal the post-processing unit's 16-cycle input window
- IN_W, 16, signed width of each incoming lane product
- ACC_W, 24, signed accumulator width per lane
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a tile; sampled only in IDLE
- k_tiles  in  4  number of K passes; sampled with start; 0 means 16
- cfg_scale  in  8  FP8 E4M3 scale; latched at start
- cfg_bias  in  8  bias; latched at start
- in_valid  in  1  row product valid
- in_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W], signed
- in_ready  out  1  high only in ACCUM
- ppu_valid  out  1  one-cycle tile-start pulse to the post-processing unit
- ppu_partial_sum  out  LANES*ACC_W  lane i at [i*24 +: 24]; zero outside drain rows
- ppu_scale  out  8  latched cfg_scale
- ppu_bias  out  8  latched cfg_bias
- ppu_done  in  1  completion pulse from the post-processing unit
- busy  out  1  high in any state other than IDLE
- tile_done  out  1  one-cycle pulse when a tile is fully processed
- overflow  out  1  sticky saturation flag; cleared on the next accepted start

## Operation
- All outputs are registered. Reset value of every output is 0, and the state returns to IDLE. The accumulator buffer, row counter and pass counter are cleared.
- State IDLE:
  - start=1: latch k_tiles, cfg_scale and cfg_bias; clear overflow, the row counter and the pass counter; go to ACCUM.
  - Any other input is ignored.
- State ACCUM:
  - in_ready=1. Each cycle with in_valid=1 is a transfer to row `row_cnt`.
  - On pass 0, acc[row][i] = sign-extend(in_data lane i).
  - On later passes, acc[row][i] = sat24(acc[row][i] + sext(lane i)).
    - Saturation clamps to +8388607 or −8388608 and sets overflow.
  - row_cnt wraps 15→0 and increments pass_cnt.
  - A transfer at row 15 of the final pass (pass_cnt = k_tiles−1, where k_tiles=0 counts as 16) goes to DRAIN_VALID.
  - Gaps in in_valid stall without side effects.
- State DRAIN_VALID (1 cycle):
  - ppu_valid=1 and ppu_partial_sum=0.
  - Next state is DRAIN with drain counter 0.
- State DRAIN (16 cycles):
  - Drain cycle d drives ppu_partial_sum = acc[d]; ppu_valid=0.
  - After d=15, go to WAIT_DONE and drive ppu_partial_sum to 0.
- State WAIT_DONE:
  - Holds ppu_scale and ppu_bias stable.
  - ppu_done=1 produces tile_done=1 for one cycle, then return to IDLE.
- start while busy is ignored and does not affect the latched configuration.
- ppu_done outside WAIT_DONE is ignored.
- ppu_scale and ppu_bias stay stable from the start cycle +1 until the next accepted start.

## Timing
- The accepting start edge is at cycle S. From S+1: busy=1 and in_ready=1.
- The final transfer edge is at cycle T. Then:
  - in_ready=0 from T+1.
  - ppu_valid=1 during T+1 only.
  - Rows 0..15 appear during T+2..T+17, back-to-back with no gaps. This matches the receiver's one-cycle-delayed 16-cycle write window.
- In WAIT_DONE from T+18, the ppu_done edge is at cycle W. Then:
  - tile_done=1 and busy=0 during W+1.
  - start is accepted at the W+1 edge at the earliest.
- Minimum cycles per tile: 16·k_tiles + 17 + post-processing latency + 1.
- Reset asserted mid-operation (any state) immediately forces IDLE with all outputs 0. No partial drain is completed or resumed.

## Test plan
- **Single pass:** k_tiles=1, row r lane i = r·16+i, no gaps.
  - ppu_valid at T+1.
  - Cycle T+2+r carries lane i = r·16+i, sign-extended to 24 bits.
  - tile_done one cycle after ppu_done.
- **Multi-pass accumulate:** k_tiles=3, every lane = −5 each pass.
  - Every drained lane = 24'hFFFFF1 (−15).
  - overflow=0.
- **Saturation:** k_tiles=0 (16 passes), every lane = 32767.
  - Drained lanes = 524272, with no saturation.
  - Repeat with an 8-bit-preloaded accumulator forced via 300 passes split across tiles is not possible. Instead use IN_W=24 override, lane = 8388607, k_tiles=2.
  - Drained lanes = 8388607; overflow=1.
- **Backpressure gaps:** k_tiles=2, in_valid toggled 1-0-1 for random gaps.
  - Results are identical to the gap-free run.
  - ppu_valid only after the 32nd transfer.
- **Busy protection:** start pulsed during DRAIN with cfg_scale=8'h40.
  - Drain unaffected.
  - ppu_scale keeps its original value.
  - No new tile until after tile_done.
- **Reset mid-drain:** rst_n low at drain row 7.
  - All outputs 0 immediately.
  - After release, a new start and k_tiles=1 tile drains correct fresh data with no residue from the old buffer.

Source files
------------

// File: rtl/psum_tile_sender_if.sv
// Bundle between the systolic array output, the partial-sum sender and the
// post-processing unit's partial-sum input. The sender is the master.
interface psum_tile_sender_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 24
) ();
    logic                   start;
    logic [3:0]             k_tiles;
    logic [7:0]             cfg_scale;
    logic [7:0]             cfg_bias;
    logic                   in_valid;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   in_ready;
    logic                   ppu_valid;
    logic [LANES*ACC_W-1:0] ppu_partial_sum;
    logic [7:0]             ppu_scale;
    logic [7:0]             ppu_bias;
    logic                   ppu_done;
    logic                   busy;
    logic                   tile_done;
    logic                   overflow;

    modport master (
        input  start, k_tiles, cfg_scale, cfg_bias, in_valid, in_data, ppu_done,
        output in_ready, ppu_valid, ppu_partial_sum, ppu_scale, ppu_bias,
               busy, tile_done, overflow
    );

    modport slave (
        output start, k_tiles, cfg_scale, cfg_bias, in_valid, in_data, ppu_done,
        input  in_ready, ppu_valid, ppu_partial_sum, ppu_scale, ppu_bias,
               busy, tile_done, overflow
    );
endinterface

// File: rtl/psum_tile_sender.sv
// Accumulates signed row products over K passes into a ROWS x LANES tile of
// saturating accumulators, then streams the tile to the post-processing unit
// as a one-cycle valid pulse followed by ROWS back-to-back rows, and waits
// for the unit's completion pulse before going idle.
module psum_tile_sender #(
    parameter int unsigned LANES = 16,
    parameter int unsigned ROWS  = 16,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 24
) (
    input logic                clk,
    input logic                rst_n,
    psum_tile_sender_if.master bus
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SUM_W = ((IN_W > ACC_W) ? IN_W : ACC_W) + 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic signed [SUM_W-1:0] ACC_MAX =
        {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN =
        {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN_VALID,
        DRAIN,
        WAIT_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_cnt_q, row_cnt_d;
    logic [3:0]               pass_cnt_q, pass_cnt_d;
    logic [ROW_W-1:0]         drain_cnt_q, drain_cnt_d;
    logic [3:0]               k_tiles_q, k_tiles_d;
    logic [7:0]               ppu_scale_q, ppu_scale_d;
    logic [7:0]               ppu_bias_q, ppu_bias_d;
    logic                     in_ready_q, in_ready_d;
    logic                     ppu_valid_q, ppu_valid_d;
    logic [LANES*ACC_W-1:0]   ppu_partial_sum_q, ppu_partial_sum_d;
    logic                     busy_q, busy_d;
    logic                     tile_done_q, tile_done_d;
    logic                     overflow_q, overflow_d;
    logic signed [ACC_W-1:0]  acc_q [ROWS][LANES];
    logic signed [ACC_W-1:0]  acc_d [ROWS][LANES];

    logic                     xfer;
    logic                     sat_hit;
    logic                     psum_load;
    logic [ROW_W-1:0]         psum_row;
    logic [3:0]               k_last;
    logic signed [SUM_W-1:0]  lane_ext;
    logic signed [SUM_W-1:0]  base_ext;
    logic signed [SUM_W-1:0]  sum;

    assign xfer   = (state_q == ACCUM) && bus.in_valid;
    // k_tiles = 0 wraps to 15 here, which is exactly the last pass of 16.
    assign k_last = k_tiles_q - 4'd1;

    // Per-lane accumulate of the transferred row with saturation to ACC_W.
    always_comb begin
        acc_d    = acc_q;
        sat_hit  = 1'b0;
        lane_ext = '0;
        base_ext = '0;
        sum      = '0;
        if (xfer) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_ext = {{(SUM_W-IN_W){bus.in_data[i*IN_W+IN_W-1]}},
                            bus.in_data[i*IN_W +: IN_W]};
                if (pass_cnt_q == 4'd0) begin
                    base_ext = '0;
                end else begin
                    base_ext = {{(SUM_W-ACC_W){acc_q[row_cnt_q][i][ACC_W-1]}},
                                acc_q[row_cnt_q][i]};
                end
                sum = base_ext + lane_ext;
                if (sum > ACC_MAX) begin
                    acc_d[row_cnt_q][i] = ACC_MAX[ACC_W-1:0];
                    sat_hit             = 1'b1;
                end else if (sum < ACC_MIN) begin
                    acc_d[row_cnt_q][i] = ACC_MIN[ACC_W-1:0];
                    sat_hit             = 1'b1;
                end else begin
                    acc_d[row_cnt_q][i] = sum[ACC_W-1:0];
                end
            end
        end
    end

    // Control FSM: next state, counters, latched config and registered outputs.
    // Outputs are computed from the next state so that each one is a flop and
    // still lines up with the cycle the state is entered.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        drain_cnt_d = drain_cnt_q;
        k_tiles_d   = k_tiles_q;
        ppu_scale_d = ppu_scale_q;
        ppu_bias_d  = ppu_bias_q;
        ppu_valid_d = 1'b0;
        tile_done_d = 1'b0;
        overflow_d  = overflow_q | sat_hit;
        psum_load   = 1'b0;
        psum_row    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_tiles_d   = bus.k_tiles;
                    ppu_scale_d = bus.cfg_scale;
                    ppu_bias_d  = bus.cfg_bias;
                    overflow_d  = 1'b0;
                    row_cnt_d   = '0;
                    pass_cnt_d  = '0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        if (pass_cnt_q == k_last) begin
                            ppu_valid_d = 1'b1;
                            state_d     = DRAIN_VALID;
                        end else begin
                            pass_cnt_d = pass_cnt_q + 4'd1;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN_VALID: begin
                drain_cnt_d = '0;
                psum_load   = 1'b1;
                psum_row    = '0;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt_q == ROW_LAST) begin
                    state_d = WAIT_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                    psum_load   = 1'b1;
                    psum_row    = drain_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.ppu_done) begin
                    tile_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == ACCUM);
        busy_d     = (state_d != IDLE);
    end

    // Drain data path: the row presented next cycle, zero outside drain rows.
    always_comb begin
        ppu_partial_sum_d = '0;
        if (psum_load) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                ppu_partial_sum_d[i*ACC_W +: ACC_W] = acc_q[psum_row][i];
            end
        end
    end

    // State, counters, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            row_cnt_q         <= '0;
            pass_cnt_q        <= '0;
            drain_cnt_q       <= '0;
            k_tiles_q         <= '0;
            ppu_scale_q       <= '0;
            ppu_bias_q        <= '0;
            in_ready_q        <= 1'b0;
            ppu_valid_q       <= 1'b0;
            ppu_partial_sum_q <= '0;
            busy_q            <= 1'b0;
            tile_done_q       <= 1'b0;
            overflow_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            row_cnt_q         <= row_cnt_d;
            pass_cnt_q        <= pass_cnt_d;
            drain_cnt_q       <= drain_cnt_d;
            k_tiles_q         <= k_tiles_d;
            ppu_scale_q       <= ppu_scale_d;
            ppu_bias_q        <= ppu_bias_d;
            in_ready_q        <= in_ready_d;
            ppu_valid_q       <= ppu_valid_d;
            ppu_partial_sum_q <= ppu_partial_sum_d;
            busy_q            <= busy_d;
            tile_done_q       <= tile_done_d;
            overflow_q        <= overflow_d;
        end
    end

    // Accumulator tile buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    acc_q[r][i] <= '0;
                end
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.ppu_valid       = ppu_valid_q;
    assign bus.ppu_partial_sum = ppu_partial_sum_q;
    assign bus.ppu_scale       = ppu_scale_q;
    assign bus.ppu_bias        = ppu_bias_q;
    assign bus.busy            = busy_q;
    assign bus.tile_done       = tile_done_q;
    assign bus.overflow        = overflow_q;

endmodule

// File: tb/tb_psum_tile_sender.sv
// Randomized bench for psum_tile_sender: expected tiles come from a plain
// integer sum-with-clamp model of the row data fed to the design.
`timescale 1ns/1ps
module tb_psum_tile_sender;

    localparam int LANES     = 16;
    localparam int ROWS      = 16;
    localparam int ACC_W     = 24;
    localparam int IN_W      = 16;
    localparam int IN_W_WIDE = 24;
    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;

    typedef logic [383:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_tile_sender_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();
    psum_tile_sender_if #(.LANES(LANES), .IN_W(IN_W_WIDE), .ACC_W(ACC_W)) bus_w ();

    psum_tile_sender #(.LANES(LANES), .ROWS(ROWS), .IN_W(IN_W), .ACC_W(ACC_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    psum_tile_sender #(.LANES(LANES), .ROWS(ROWS), .IN_W(IN_W_WIDE), .ACC_W(ACC_W)) u_dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         data [16][16][16];   // [pass][row][lane]
    int         exp_acc [16][16];    // [row][lane]
    bit         exp_ovf;
    logic [7:0] exp_scale;
    logic [7:0] exp_bias;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each lane is the running sum over passes, clamped at every step.
    task automatic model(input int k);
        int     passes;
        longint acc;
        passes  = (k == 0) ? 16 : k;
        exp_ovf = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < LANES; i++) begin
                acc = 0;
                for (int p = 0; p < passes; p++) begin
                    acc = acc + longint'(data[p][r][i]);
                    if (acc > ACC_MAX) begin
                        acc = ACC_MAX; exp_ovf = 1'b1;
                    end else if (acc < ACC_MIN) begin
                        acc = ACC_MIN; exp_ovf = 1'b1;
                    end
                end
                exp_acc[r][i] = int'(acc);
            end
        end
    endtask

    function automatic vec_t exp_row(input int r);
        vec_t v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*ACC_W +: ACC_W] = 24'(exp_acc[r][i]);
        return v;
    endfunction

    function automatic logic [LANES*IN_W-1:0] pack_in(input int p, input int r);
        logic [LANES*IN_W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*IN_W +: IN_W] = 16'(data[p][r][i]);
        return v;
    endfunction

    task automatic fill_const(input int val);
        for (int p = 0; p < 16; p++)
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < LANES; i++) data[p][r][i] = val;
    endtask

    task automatic fill_rand();
        logic signed [15:0] s;
        for (int p = 0; p < 16; p++)
            for (int r = 0; r < ROWS; r++)
                for (int i = 0; i < LANES; i++) begin
                    s = 16'($urandom);
                    data[p][r][i] = int'(s);
                end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"},  vec_t'(bus.in_ready),        '0);
        check({tag, "_ppu_valid"}, vec_t'(bus.ppu_valid),       '0);
        check({tag, "_psum"},      vec_t'(bus.ppu_partial_sum), '0);
        check({tag, "_scale"},     vec_t'(bus.ppu_scale),       '0);
        check({tag, "_bias"},      vec_t'(bus.ppu_bias),        '0);
        check({tag, "_busy"},      vec_t'(bus.busy),            '0);
        check({tag, "_tile_done"}, vec_t'(bus.tile_done),       '0);
        check({tag, "_overflow"},  vec_t'(bus.overflow),        '0);
    endtask

    // One full tile on the 16-bit instance. Called and returns at a negedge
    // with the design idle (or just reset when abort_row >= 0).
    task automatic run_tile(input int k, input int gap_pct, input bit poke, input int abort_row);
        int         passes;
        int         gaps;
        int         wait_cycles;
        logic [7:0] sc;
        logic [7:0] bi;
        passes = (k == 0) ? 16 : k;
        sc = 8'($urandom);
        bi = 8'($urandom);
        model(k);

        bus.start     = 1'b1;
        bus.k_tiles   = 4'(k);
        bus.cfg_scale = sc;
        bus.cfg_bias  = bi;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.k_tiles   = 4'($urandom);
        bus.cfg_scale = 8'($urandom);
        bus.cfg_bias  = 8'($urandom);
        exp_scale = sc;
        exp_bias  = bi;
        check("start_busy",     vec_t'(bus.busy),      vec_t'(1));
        check("start_in_ready", vec_t'(bus.in_ready),  vec_t'(1));
        check("start_overflow", vec_t'(bus.overflow),  '0);
        check("start_scale",    vec_t'(bus.ppu_scale), vec_t'(exp_scale));
        check("start_bias",     vec_t'(bus.ppu_bias),  vec_t'(exp_bias));

        for (int p = 0; p < passes; p++) begin
            for (int r = 0; r < ROWS; r++) begin
                gaps = 0;
                while (gap_pct > 0 && gaps < 3 && int'($urandom_range(99)) < gap_pct) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 256'($urandom);
                    @(negedge clk);
                    check("gap_in_ready",  vec_t'(bus.in_ready),  vec_t'(1));
                    check("gap_ppu_valid", vec_t'(bus.ppu_valid), '0);
                    gaps++;
                end
                bus.in_valid = 1'b1;
                bus.in_data  = pack_in(p, r);
                @(negedge clk);
                if (!(p == passes - 1 && r == ROWS - 1)) begin
                    check("accum_ppu_valid", vec_t'(bus.ppu_valid), '0);
                    check("accum_in_ready",  vec_t'(bus.in_ready),  vec_t'(1));
                end
            end
        end
        bus.in_valid = 1'b0;

        // Cycle T+1: valid pulse, no data, no more input accepted.
        check("t1_ppu_valid", vec_t'(bus.ppu_valid),       vec_t'(1));
        check("t1_in_ready",  vec_t'(bus.in_ready),        '0);
        check("t1_psum",      vec_t'(bus.ppu_partial_sum), '0);

        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            if (r == abort_row) begin
                rst_n = 1'b0;
                #1;
                check_zero_outputs("reset_mid_drain");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check("drain_row",       vec_t'(bus.ppu_partial_sum), exp_row(r));
            check("drain_ppu_valid", vec_t'(bus.ppu_valid),       '0);
            check("drain_scale",     vec_t'(bus.ppu_scale),       vec_t'(exp_scale));
            if (poke) begin
                bus.start     = (r == 3);
                bus.cfg_scale = 8'h40;
                bus.cfg_bias  = 8'h5A;
                bus.ppu_done  = (r == 5);
            end
        end
        bus.start    = 1'b0;
        bus.ppu_done = 1'b0;

        @(negedge clk);
        check("wait_psum_zero", vec_t'(bus.ppu_partial_sum), '0);
        check("wait_busy",      vec_t'(bus.busy),            vec_t'(1));
        wait_cycles = int'($urandom_range(3));
        for (int c = 0; c < wait_cycles; c++) begin
            @(negedge clk);
            check("wait_no_tile_done", vec_t'(bus.tile_done), '0);
        end

        bus.ppu_done = 1'b1;
        @(negedge clk);
        bus.ppu_done = 1'b0;
        check("tile_done",      vec_t'(bus.tile_done), vec_t'(1));
        check("done_busy",      vec_t'(bus.busy),      '0);
        check("done_scale",     vec_t'(bus.ppu_scale), vec_t'(exp_scale));
        check("done_bias",      vec_t'(bus.ppu_bias),  vec_t'(exp_bias));
        check("done_overflow",  vec_t'(bus.overflow),  vec_t'(exp_ovf));
        @(negedge clk);
        check("tile_done_pulse", vec_t'(bus.tile_done), '0);
        check("idle_busy",       vec_t'(bus.busy),      '0);
        check("idle_in_ready",   vec_t'(bus.in_ready),  '0);
    endtask

    // Overflow path on the 24-bit-input instance: two passes of +max per lane.
    task automatic run_wide_saturation();
        logic [LANES*IN_W_WIDE-1:0] full;
        vec_t                       exp_v;
        full  = '0;
        exp_v = '0;
        for (int i = 0; i < LANES; i++) begin
            full[i*IN_W_WIDE +: IN_W_WIDE] = 24'h7FFFFF;
            exp_v[i*ACC_W +: ACC_W]        = 24'h7FFFFF;
        end

        bus_w.start     = 1'b1;
        bus_w.k_tiles   = 4'd2;
        bus_w.cfg_scale = 8'h3C;
        bus_w.cfg_bias  = 8'h11;
        @(negedge clk);
        bus_w.start = 1'b0;
        check("w_start_busy", vec_t'(bus_w.busy), vec_t'(1));
        for (int t = 0; t < 2 * ROWS; t++) begin
            bus_w.in_valid = 1'b1;
            bus_w.in_data  = full;
            @(negedge clk);
            if (t == ROWS - 1) check("w_ovf_before_sat", vec_t'(bus_w.overflow), '0);
            if (t == ROWS)     check("w_ovf_after_sat",  vec_t'(bus_w.overflow), vec_t'(1));
        end
        bus_w.in_valid = 1'b0;
        check("w_ppu_valid", vec_t'(bus_w.ppu_valid), vec_t'(1));
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            check("w_drain_sat", vec_t'(bus_w.ppu_partial_sum), exp_v);
        end
        @(negedge clk);
        check("w_wait_overflow", vec_t'(bus_w.overflow), vec_t'(1));
        bus_w.ppu_done = 1'b1;
        @(negedge clk);
        bus_w.ppu_done = 1'b0;
        check("w_tile_done",      vec_t'(bus_w.tile_done), vec_t'(1));
        check("w_sticky_overflow", vec_t'(bus_w.overflow), vec_t'(1));
        check("w_scale",          vec_t'(bus_w.ppu_scale), vec_t'(8'h3C));
        bus_w.start   = 1'b1;
        bus_w.k_tiles = 4'd1;
        @(negedge clk);
        bus_w.start = 1'b0;
        check("w_overflow_cleared", vec_t'(bus_w.overflow), '0);
        check("w_restart_busy",     vec_t'(bus_w.busy),     vec_t'(1));
    endtask

    initial begin
        bus.start = 1'b0;   bus.k_tiles = '0;   bus.cfg_scale = '0;   bus.cfg_bias = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;  bus.ppu_done = 1'b0;
        bus_w.start = 1'b0; bus_w.k_tiles = '0; bus_w.cfg_scale = '0; bus_w.cfg_bias = '0;
        bus_w.in_valid = 1'b0; bus_w.in_data = '0; bus_w.ppu_done = 1'b0;

        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        check("reset_w_busy", vec_t'(bus_w.busy), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp: row r lane i = r*16 + i, single pass.
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < LANES; i++) data[0][r][i] = r * 16 + i;
        run_tile(1, 0, 1'b0, -1);

        fill_const(-5);
        run_tile(3, 0, 1'b0, -1);

        fill_const(32767);
        run_tile(0, 0, 1'b0, -1);

        // Same random data without and with input gaps.
        fill_rand();
        run_tile(2, 0, 1'b0, -1);
        run_tile(2, 40, 1'b0, -1);

        for (int t = 0; t < 3; t++) begin
            fill_rand();
            run_tile(int'($urandom_range(1, 4)), 30, 1'b0, -1);
        end

        // start and ppu_done poked while draining must be ignored.
        fill_rand();
        run_tile(1, 0, 1'b1, -1);
        @(negedge clk);
        check("poke_no_new_tile", vec_t'(bus.busy), '0);

        fill_rand();
        run_tile(2, 0, 1'b0, 7);
        check_zero_outputs("after_reset");
        fill_rand();
        run_tile(1, 0, 1'b0, -1);

        run_wide_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
